// File: rtl/arbiter_vote_capture.sv
// Capture stage for WIDTH arbiter PUF channels: synchroniser, repeated sampling,
// per-channel majority vote and stability flag behind a start/busy/valid handshake.
module arbiter_vote_capture #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned VOTES       = 5
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] stable,
    output logic             q_valid
);

    localparam int unsigned CW = $clog2(VOTES + 1);
    localparam int unsigned PW = $clog2(SYNC_STAGES + VOTES + 1);
    localparam logic [CW-1:0] HALF        = CW'(VOTES / 2);
    localparam logic [CW-1:0] ALL         = CW'(VOTES);
    localparam logic [PW-1:0] FLUSH_LAST  = PW'(SYNC_STAGES - 1);
    localparam logic [PW-1:0] SAMPLE_LAST = PW'(VOTES - 1);
    localparam logic [PW-1:0] PHASE_ONE   = PW'(1);

    typedef enum logic [1:0] {StIdle, StFlush, StSample} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] q_q, q_d, stable_q, stable_d;
    logic             q_valid_q, q_valid_d;
    logic             last_sample;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= d;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        last_sample = 1'b0;
        unique case (state_q)
            StIdle: begin
                phase_d = '0;
                if (start) state_d = StFlush;
            end
            // Drain samples taken before the request out of the synchroniser.
            StFlush: begin
                if (phase_q == FLUSH_LAST) begin
                    phase_d = '0;
                    state_d = StSample;
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end
            StSample: begin
                if (phase_q == SAMPLE_LAST) begin
                    last_sample = 1'b1;
                    phase_d     = '0;
                    state_d     = StIdle;
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        q_d       = q_q;
        stable_d  = stable_q;
        q_valid_d = last_sample;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = (state_q == StSample) ? cnt_q[i] + CW'(sync_q[SYNC_STAGES-1][i]) : '0;
            if (last_sample) begin
                q_d[i]      = (cnt_d[i] > HALF);
                stable_d[i] = (cnt_d[i] == '0) || (cnt_d[i] == ALL);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            q_q       <= '0;
            stable_q  <= '0;
            q_valid_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            q_q       <= q_d;
            stable_q  <= stable_d;
            q_valid_q <= q_valid_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign busy    = (state_q != StIdle);
    assign q       = q_q;
    assign stable  = stable_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_arbiter_vote_capture.sv
// Bench for arbiter_vote_capture: three parameterisations checked every cycle against a
// sample-history model, plus directed reset, vote, handshake and latency scenarios.
module tb_arbiter_vote_capture;

    localparam int NCYC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn0, start0, busy0, qv0;
    logic [7:0]  d0, q0, s0;
    logic        rstn1, start1, busy1, qv1;
    logic [0:0]  d1, q1, s1;
    logic        rstn2, start2, busy2, qv2;
    logic [31:0] d2, q2, s2;

    arbiter_vote_capture #(.WIDTH(8), .SYNC_STAGES(2), .VOTES(5)) u_dut0 (
        .Clk(clk), .Rst_n(rstn0), .d(d0), .start(start0),
        .busy(busy0), .q(q0), .stable(s0), .q_valid(qv0)
    );
    arbiter_vote_capture #(.WIDTH(1), .SYNC_STAGES(3), .VOTES(1)) u_dut1 (
        .Clk(clk), .Rst_n(rstn1), .d(d1), .start(start1),
        .busy(busy1), .q(q1), .stable(s1), .q_valid(qv1)
    );
    arbiter_vote_capture #(.WIDTH(32), .SYNC_STAGES(2), .VOTES(255)) u_dut2 (
        .Clk(clk), .Rst_n(rstn2), .d(d2), .start(start2),
        .busy(busy2), .q(q2), .stable(s2), .q_valid(qv2)
    );

    int unsigned pw[3] = '{8, 1, 32};
    int unsigned ps[3] = '{2, 3, 2};
    int unsigned pv[3] = '{5, 1, 255};

    logic [63:0] dv[3];
    logic        sv[3];
    logic        rv[3];
    logic [63:0] dh[3][NCYC];
    bit          m_act[3];
    int          m_e0[3];
    logic [63:0] m_q[3];
    logic [63:0] m_s[3];
    logic        m_qv[3];
    int          qv_seen[3];
    int          n;
    int          tests;
    int          fails;

    function automatic logic [63:0] get_q(int id);
        case (id)
            0:       return {56'b0, q0};
            1:       return {63'b0, q1};
            default: return {32'b0, q2};
        endcase
    endfunction

    function automatic logic [63:0] get_s(int id);
        case (id)
            0:       return {56'b0, s0};
            1:       return {63'b0, s1};
            default: return {32'b0, s2};
        endcase
    endfunction

    function automatic logic get_busy(int id);
        case (id)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_qv(int id);
        case (id)
            0:       return qv0;
            1:       return qv1;
            default: return qv2;
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected behaviour from the rules: a request accepted at edge e0 votes on the d values
    // present at edges e0+1 .. e0+VOTES and reports at edge e0+SYNC_STAGES+VOTES.
    task automatic model_edge(int id);
        int unsigned cnt;
        if (!rv[id]) begin
            m_act[id] = 1'b0;
            m_q[id]   = '0;
            m_s[id]   = '0;
            m_qv[id]  = 1'b0;
        end else begin
            m_qv[id] = 1'b0;
            if (m_act[id] && n == m_e0[id] + int'(ps[id] + pv[id])) begin
                for (int c = 0; c < int'(pw[id]); c++) begin
                    cnt = 0;
                    for (int k = 1; k <= int'(pv[id]); k++) cnt += 32'(dh[id][m_e0[id] + k][c]);
                    m_q[id][c] = (cnt > pv[id] / 2);
                    m_s[id][c] = (cnt == 0) || (cnt == pv[id]);
                end
                m_act[id] = 1'b0;
                m_qv[id]  = 1'b1;
            end else if (!m_act[id] && sv[id]) begin
                m_act[id] = 1'b1;
                m_e0[id]  = n;
            end
        end
        dh[id][n] = dv[id] & ((64'd1 << pw[id]) - 64'd1);
    endtask

    task automatic tick();
        d0 = dv[0][7:0];  start0 = sv[0]; rstn0 = rv[0];
        d1 = dv[1][0:0];  start1 = sv[1]; rstn1 = rv[1];
        d2 = dv[2][31:0]; start2 = sv[2]; rstn2 = rv[2];
        @(posedge clk);
        n++;
        if (n >= NCYC) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", n, NCYC);
            $fatal(1, "cycle budget exceeded");
        end
        for (int id = 0; id < 3; id++) model_edge(id);
        #1;
        for (int id = 0; id < 3; id++) begin
            if (get_qv(id)) qv_seen[id]++;
            chk($sformatf("busy%0d@%0d", id, n), 64'(get_busy(id)), 64'(m_act[id]));
            chk($sformatf("qv%0d@%0d", id, n), 64'(get_qv(id)), 64'(m_qv[id]));
            chk($sformatf("q%0d@%0d", id, n), get_q(id), m_q[id]);
            chk($sformatf("stable%0d@%0d", id, n), get_s(id), m_s[id]);
        end
    endtask

    task automatic run_lat(int id, int exp_lat, string tag);
        int e0;
        int lat = -1;
        bit got = 1'b0;
        sv[id] = 1'b1;
        tick();
        e0 = n;
        sv[id] = 1'b0;
        for (int i = 0; i < exp_lat + 20 && !got; i++) begin
            tick();
            if (get_qv(id)) begin
                got = 1'b1;
                lat = n - e0;
            end
        end
        chk(tag, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        int base;
        logic [4:0] pat;
        tests = 0;
        fails = 0;
        n = 0;
        for (int id = 0; id < 3; id++) begin
            dv[id] = {$urandom, $urandom};
            sv[id] = 1'b0;
            rv[id] = 1'b0;
            m_act[id] = 1'b0;
            m_e0[id] = 0;
            m_q[id] = '0;
            m_s[id] = '0;
            m_qv[id] = 1'b0;
            qv_seen[id] = 0;
        end

        // Reset with d all ones, then idle without a request.
        dv[0] = 64'hFF;
        repeat (3) tick();
        for (int id = 0; id < 3; id++) rv[id] = 1'b1;
        repeat (5) tick();
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_q", 64'(q0), 64'd0);
        chk("rst_stable", 64'(s0), 64'd0);
        chk("rst_no_qv", 64'(qv_seen[0]), 64'd0);

        // Constant input.
        dv[0] = 64'hA5;
        run_lat(0, 7, "lat_const");
        chk("const_q", 64'(q0), 64'hA5);
        chk("const_stable", 64'(s0), 64'hFF);
        tick();
        chk("const_qv_one_cycle", 64'(qv0), 64'd0);

        // Majority vote on bit 0; pattern bit k is the value at edge E0+1+k.
        for (int r = 0; r < 2; r++) begin
            pat = (r == 0) ? 5'b01011 : 5'b01010;
            dv[0] = 64'h0;
            sv[0] = 1'b1;
            tick();
            sv[0] = 1'b0;
            for (int k = 0; k < 5; k++) begin
                dv[0] = {63'b0, pat[k]};
                tick();
            end
            dv[0] = 64'h0;
            repeat (2) tick();
            chk($sformatf("vote%0d_qv", r), 64'(qv0), 64'd1);
            chk($sformatf("vote%0d_q", r), 64'(q0), (r == 0) ? 64'h01 : 64'h00);
            chk($sformatf("vote%0d_stable", r), 64'(s0), 64'hFE);
        end

        // Start held for 20 cycles; later starts are only taken once the FSM is idle again.
        base = qv_seen[0];
        sv[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            dv[0] = {$urandom, $urandom};
            tick();
        end
        sv[0] = 1'b0;
        repeat (10) tick();
        chk("hold_qv_count", 64'(qv_seen[0] - base), 64'd3);

        // Starts mid-busy are dropped; a start in the q_valid cycle is taken.
        base = qv_seen[0];
        for (int i = 0; i <= 8; i++) begin
            sv[0] = (i == 0 || i == 2 || i == 5 || i == 8);
            tick();
            if (i == 7) chk("midbusy_qv_at7", 64'(qv0), 64'd1);
        end
        sv[0] = 1'b0;
        chk("restart_busy", 64'(busy0), 64'd1);
        repeat (8) tick();
        chk("midbusy_qv_count", 64'(qv_seen[0] - base), 64'd2);

        // Reset in the middle of an evaluation.
        dv[0] = 64'h3C;
        run_lat(0, 7, "lat_pre_rst");
        chk("pre_rst_q", 64'(q0), 64'h3C);
        base = qv_seen[0];
        sv[0] = 1'b1;
        tick();
        sv[0] = 1'b0;
        repeat (3) tick();
        rv[0] = 1'b0;
        tick();
        rv[0] = 1'b1;
        chk("midrst_busy", 64'(busy0), 64'd0);
        chk("midrst_q", 64'(q0), 64'd0);
        repeat (6) tick();
        chk("midrst_no_qv", 64'(qv_seen[0] - base), 64'd0);
        run_lat(0, 7, "lat_after_rst");
        chk("after_rst_q", 64'(q0), 64'h3C);

        // Other parameterisations.
        dv[1] = 64'h1;
        run_lat(1, 4, "lat_v1");
        chk("v1_q", 64'(q1), 64'h1);
        chk("v1_stable", 64'(s1), 64'h1);
        dv[2] = 64'hFFFF_FFFF;
        run_lat(2, 257, "lat_v255");
        chk("v255_q", 64'(q2), 64'hFFFF_FFFF);
        chk("v255_stable", 64'(s2), 64'hFFFF_FFFF);

        // Random traffic against the model.
        for (int i = 0; i < 900; i++) begin
            for (int id = 0; id < 3; id++) begin
                dv[id] = {$urandom, $urandom};
                sv[id] = ($urandom_range(3) == 0);
            end
            rv[0] = ($urandom_range(99) != 0);
            tick();
        end
        for (int id = 0; id < 3; id++) begin
            sv[id] = 1'b0;
            rv[id] = 1'b1;
        end
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
